// File: rtl/mips_pkg.sv
// Shared datapath constants: ALU operand-source slot indices, data width and PC increment.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  localparam int ALU_SRC_RS       = 0;
  localparam int ALU_SRC_SHAMT    = 1;
  localparam int ALU_SRC_SEXT     = 2;
  localparam int ALU_SRC_SEXT_SL2 = 3;
  localparam int ALU_SRC_PLUS4    = 4;
  localparam int ALU_SRC_ZEXT     = 5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_st_e;

endpackage

// File: rtl/sel_comb_n.sv
// Combinational N-way operand select with legality check.
// Illegal selects never route din bits to val; they yield ILLEGAL_VAL.
module sel_comb_n #(
  parameter int                 WIDTH       = 32,
  parameter int                 NUM_IN      = 8,
  parameter int                 SEL_W       = $clog2(NUM_IN),
  parameter logic [NUM_IN-1:0]  LEGAL_MASK  = NUM_IN'(8'b0011_1111),
  parameter int                 CONST_SLOT  = 4,
  parameter logic [31:0]        CONST_VAL   = 32'd4,
  parameter logic [31:0]        ILLEGAL_VAL = 32'd0
) (
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        val,
  output logic                    illegal
);

  localparam logic [WIDTH-1:0] CONST_W   = WIDTH'(CONST_VAL);
  localparam logic [WIDTH-1:0] ILLEGAL_W = WIDTH'(ILLEGAL_VAL);

  // Unmatched sel (>= NUM_IN) falls through to the illegal defaults.
  always_comb begin
    val     = ILLEGAL_W;
    illegal = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        if (i == CONST_SLOT) begin
          val     = CONST_W;
          illegal = 1'b0;
        end else if (LEGAL_MASK[i]) begin
          val     = din[i*WIDTH +: WIDTH];
          illegal = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Operand selector with a one-entry valid/ready output register and sticky
// illegal-select error reporting.
//
// state    | meaning
// ST_EMPTY | no unconsumed value in dout (out_valid=0)
// ST_FULL  | dout holds a value awaiting out_ready (out_valid=1)
module operand_sel_pipe
  import mips_pkg::*;
#(
  parameter int                 WIDTH       = DATA_W,
  parameter int                 NUM_IN      = 8,
  parameter int                 SEL_W       = $clog2(NUM_IN),
  parameter logic [NUM_IN-1:0]  LEGAL_MASK  = NUM_IN'(8'b0011_1111),
  parameter int                 CONST_SLOT  = ALU_SRC_PLUS4,
  parameter logic [31:0]        CONST_VAL   = PC_INC,
  parameter logic [31:0]        ILLEGAL_VAL = 32'd0,
  parameter int                 ERRCNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        dout_sel,
  output logic                    err,
  output logic [ERRCNT_W-1:0]     err_cnt,
  input  logic                    err_clr
);

  pipe_st_e         state, state_nxt;
  logic [WIDTH-1:0] sel_val;
  logic             sel_illegal;
  logic             accept;

  sel_comb_n #(
    .WIDTH      (WIDTH),
    .NUM_IN     (NUM_IN),
    .SEL_W      (SEL_W),
    .LEGAL_MASK (LEGAL_MASK),
    .CONST_SLOT (CONST_SLOT),
    .CONST_VAL  (CONST_VAL),
    .ILLEGAL_VAL(ILLEGAL_VAL)
  ) u_sel (
    .din    (din),
    .sel    (sel),
    .val    (sel_val),
    .illegal(sel_illegal)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL: begin
        if (accept)         state_nxt = ST_FULL;
        else if (out_ready) state_nxt = ST_EMPTY;
      end
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      dout     <= '0;
      dout_sel <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dout     <= sel_val;
        dout_sel <= sel;
      end
      // Clear wins over a same-cycle illegal accept.
      if (err_clr) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end else if (accept && sel_illegal) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
